// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA timing constant sets and axis length helpers
package vga_timing_pkg;

  // 800x600@60 timing. This is the default set.
  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FP     = 40;
  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_H_BP     = 88;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FP     = 1;
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_V_BP     = 23;
  localparam bit SVGA_H_POL    = 1'b1;
  localparam bit SVGA_V_POL    = 1'b1;

  // 640x480@60 timing, with negative sync polarity.
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam bit VGA_H_POL    = 1'b0;
  localparam bit VGA_V_POL    = 1'b0;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - wrapping position counter with active/sync decode for one axis
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = SVGA_H_ACTIVE,
  parameter int FP     = SVGA_H_FP,
  parameter int SYNC   = SVGA_H_SYNC,
  parameter int BP     = SVGA_H_BP,
  parameter bit POL    = SVGA_H_POL,
  parameter int W      = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         sync,
  output logic         wrap,
  output logic         active_next
);

  localparam int TOTAL = h_total(ACTIVE, FP, SYNC, BP);
  localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END  = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_BEG = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_END = W'(ACTIVE + FP + SYNC);

  if (TOTAL > (1 << W) || ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_cfg
    $error("vga_axis_counter: interval below 1 or total exceeds counter width");
  end

  logic [W-1:0] count_d, count_q;
  logic         sync_d, sync_q;

  // Decode from the next count so sync and the counter change on the same edge.
  always_comb begin
    wrap    = en && (count_q == LAST);
    count_d = count_q;
    if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + W'(1);
    end
    active_next = (count_d < ACT_END);
    sync_d      = ((count_d >= SYNC_BEG) && (count_d < SYNC_END)) ? POL : ~POL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      sync_q  <= ~POL;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
    end
  end

  assign count = count_q;
  assign sync  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator with pixel clock-enable
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = SVGA_H_ACTIVE,
  parameter int H_FP     = SVGA_H_FP,
  parameter int H_SYNC   = SVGA_H_SYNC,
  parameter int H_BP     = SVGA_H_BP,
  parameter int V_ACTIVE = SVGA_V_ACTIVE,
  parameter int V_FP     = SVGA_V_FP,
  parameter int V_SYNC   = SVGA_V_SYNC,
  parameter int V_BP     = SVGA_V_BP,
  parameter bit H_POL    = SVGA_H_POL,
  parameter bit V_POL    = SVGA_V_POL,
  parameter int H_W      = 11,
  parameter int V_W      = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  output logic [H_W-1:0] count_h,
  output logic [V_W-1:0] count_v,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic           line_start,
  output logic           frame_start
);

  logic h_wrap, v_wrap, v_en;
  logic h_act_next, v_act_next;
  logic de_d, de_q;
  logic line_start_d, line_start_q;
  logic frame_start_d, frame_start_q;

  // The vertical axis only steps on the last pixel of a line.
  assign v_en = ce && h_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL), .W(H_W)
  ) u_h (
    .clk(clk), .rst(rst), .en(ce),
    .count(count_h), .sync(hsync), .wrap(h_wrap), .active_next(h_act_next)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL), .W(V_W)
  ) u_v (
    .clk(clk), .rst(rst), .en(v_en),
    .count(count_v), .sync(vsync), .wrap(v_wrap), .active_next(v_act_next)
  );

  always_comb begin
    de_d          = h_act_next && v_act_next;
    line_start_d  = h_wrap;
    frame_start_d = h_wrap && v_wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      de_q          <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // d: 800x600 defaults, g: 640x480, s: small custom, m: minimal
  logic rst_d = 1'b1, ce_d = 1'b0;
  logic rst_g = 1'b1, ce_g = 1'b0;
  logic rst_s = 1'b1, ce_s = 1'b0;
  logic rst_m = 1'b1, ce_m = 1'b0;

  logic [10:0] d_h; logic [9:0] d_v; logic d_hs, d_vs, d_de, d_ls, d_fs;
  logic [9:0]  g_h; logic [9:0] g_v; logic g_hs, g_vs, g_de, g_ls, g_fs;
  logic [3:0]  s_h; logic [3:0] s_v; logic s_hs, s_vs, s_de, s_ls, s_fs;
  logic [2:0]  m_h; logic [2:0] m_v; logic m_hs, m_vs, m_de, m_ls, m_fs;

  vga_timing_gen dut_d (
    .clk(clk), .rst(rst_d), .ce(ce_d), .count_h(d_h), .count_v(d_v),
    .hsync(d_hs), .vsync(d_vs), .de(d_de), .line_start(d_ls), .frame_start(d_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(VGA_H_ACTIVE), .H_FP(VGA_H_FP), .H_SYNC(VGA_H_SYNC), .H_BP(VGA_H_BP),
    .V_ACTIVE(VGA_V_ACTIVE), .V_FP(VGA_V_FP), .V_SYNC(VGA_V_SYNC), .V_BP(VGA_V_BP),
    .H_POL(VGA_H_POL), .V_POL(VGA_V_POL), .H_W(10), .V_W(10)
  ) dut_g (
    .clk(clk), .rst(rst_g), .ce(ce_g), .count_h(g_h), .count_v(g_v),
    .hsync(g_hs), .vsync(g_vs), .de(g_de), .line_start(g_ls), .frame_start(g_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .H_POL(1'b1), .V_POL(1'b0), .H_W(4), .V_W(4)
  ) dut_s (
    .clk(clk), .rst(rst_s), .ce(ce_s), .count_h(s_h), .count_v(s_v),
    .hsync(s_hs), .vsync(s_vs), .de(s_de), .line_start(s_ls), .frame_start(s_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(2), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .H_W(3), .V_W(3)
  ) dut_m (
    .clk(clk), .rst(rst_m), .ce(ce_m), .count_h(m_h), .count_v(m_v),
    .hsync(m_hs), .vsync(m_vs), .de(m_de), .line_start(m_ls), .frame_start(m_fs)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad, ls_cnt, fs_cnt, de_fall, hs_low, n, cyc, max_h, max_v, eh, ev;
    logic cur_ce;

    repeat (2) tick();

    check("pkg_h_total_640", h_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP), 800);
    check("pkg_v_total_480", v_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP), 525);

    // Defaults: reset with ce high, then one full line.
    ce_d = 1'b1;
    tick();
    check("d_rst_h", d_h, 0);
    check("d_rst_v", d_v, 0);
    check("d_rst_de", d_de, 1);
    check("d_rst_hs", d_hs, 0);
    check("d_rst_vs", d_vs, 0);
    check("d_rst_ls", d_ls, 0);
    check("d_rst_fs", d_fs, 0);
    rst_d = 1'b0;
    bad = 0; ls_cnt = 0; de_fall = -1;
    for (int k = 1; k <= 1056; k++) begin
      tick();
      eh = k % 1056; ev = k / 1056;
      if (d_h !== 11'(eh) || d_v !== 10'(ev)) bad++;
      if (d_hs !== (eh >= 840 && eh < 968)) bad++;
      if (d_de !== (eh < 800 && ev < 600)) bad++;
      if (d_vs !== 1'b0) bad++;
      if (d_ls !== (k == 1056)) bad++;
      if (d_fs !== 1'b0) bad++;
      if (d_ls === 1'b1) ls_cnt++;
      if (d_de === 1'b0 && de_fall < 0) de_fall = int'(d_h);
    end
    check("d_line_errors", bad, 0);
    check("d_wrap_h", d_h, 0);
    check("d_wrap_v", d_v, 1);
    check("d_wrap_ls", d_ls, 1);
    check("d_ls_count", ls_cnt, 1);
    check("d_de_fall_at", de_fall, 800);
    tick();
    check("d_after_h", d_h, 1);
    check("d_after_ls", d_ls, 0);
    ce_d = 1'b0;
    repeat (3) tick();
    check("d_hold_h", d_h, 1);
    check("d_hold_v", d_v, 1);
    ce_d = 1'b1;
    repeat (499) tick();
    check("d_mid_h", d_h, 500);
    check("d_mid_v", d_v, 1);
    rst_d = 1'b1;
    tick();
    check("d_midrst_h", d_h, 0);
    check("d_midrst_v", d_v, 0);
    check("d_midrst_de", d_de, 1);
    check("d_midrst_hs", d_hs, 0);
    ce_d = 1'b0;

    // 640x480: negative polarity, two lines.
    ce_g = 1'b1;
    tick();
    check("g_rst_hs", g_hs, 1);
    check("g_rst_vs", g_vs, 1);
    check("g_rst_de", g_de, 1);
    rst_g = 1'b0;
    bad = 0; ls_cnt = 0; hs_low = 0;
    for (int k = 1; k <= 1600; k++) begin
      tick();
      eh = k % 800; ev = k / 800;
      if (g_h !== 10'(eh) || g_v !== 10'(ev)) bad++;
      if (g_hs !== !(eh >= 656 && eh < 752)) bad++;
      if (g_de !== (eh < 640 && ev < 480)) bad++;
      if (g_vs !== 1'b1) bad++;
      if (g_hs === 1'b0) hs_low++;
      if (g_ls === 1'b1) ls_cnt++;
    end
    check("g_line_errors", bad, 0);
    check("g_hs_low_cycles", hs_low, 192);
    check("g_ls_count", ls_cnt, 2);
    check("g_end_v", g_v, 2);
    ce_g = 1'b0;

    // Minimal config: both axes wrap at 5.
    rst_m = 1'b0; ce_m = 1'b1;
    bad = 0; fs_cnt = 0; max_h = 0; max_v = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      eh = k % 5; ev = (k / 5) % 5;
      if (m_h !== 3'(eh) || m_v !== 3'(ev)) bad++;
      if (m_hs !== (eh == 3) || m_vs !== (ev == 3)) bad++;
      if (m_de !== (eh < 2 && ev < 2)) bad++;
      if (m_ls !== (eh == 0) || m_fs !== (k == 25)) bad++;
      if (m_fs === 1'b1) fs_cnt++;
      if (int'(m_h) > max_h) max_h = int'(m_h);
      if (int'(m_v) > max_v) max_v = int'(m_v);
    end
    check("m_errors", bad, 0);
    check("m_max_h", max_h, 4);
    check("m_max_v", max_v, 4);
    check("m_fs_count", fs_cnt, 1);
    ce_m = 1'b0;

    // Small config (15x10, vsync active-low), pseudo-random ce over two frames.
    rst_s = 1'b0;
    bad = 0; ls_cnt = 0; fs_cnt = 0; n = 0; cyc = 0; max_v = 0;
    while (n < 300 && cyc < 3000) begin
      ce_s = ($urandom_range(0, 2) != 0);
      cur_ce = ce_s;
      tick();
      cyc++;
      if (cur_ce) n++;
      eh = n % 15; ev = (n / 15) % 10;
      if (s_h !== 4'(eh) || s_v !== 4'(ev)) bad++;
      if (s_hs !== (eh >= 10 && eh < 13)) bad++;
      if (s_vs !== !(ev >= 5 && ev < 7)) bad++;
      if (s_de !== (eh < 8 && ev < 4)) bad++;
      if (s_ls !== (cur_ce && eh == 0)) bad++;
      if (s_fs !== (cur_ce && (n % 150) == 0)) bad++;
      if (s_ls === 1'b1) ls_cnt++;
      if (s_fs === 1'b1) begin
        fs_cnt++;
        if (n != 150 * fs_cnt) bad++;
      end
      if (int'(s_v) > max_v) max_v = int'(s_v);
    end
    check("s_ce_cycles", n, 300);
    check("s_errors", bad, 0);
    check("s_ls_count", ls_cnt, 20);
    check("s_fs_count", fs_cnt, 2);
    check("s_max_v", max_v, 9);
    ce_s = 1'b0;
    tick();
    check("s_pulse_drop_fs", s_fs, 0);
    check("s_pulse_drop_ls", s_ls, 0);
    check("s_hold_h", s_h, 0);

    // Reset inside both sync intervals, with ce high.
    ce_s = 1'b1;
    repeat (101) tick();
    check("s_pre_h", s_h, 11);
    check("s_pre_v", s_v, 6);
    check("s_pre_hs", s_hs, 1);
    check("s_pre_vs", s_vs, 0);
    rst_s = 1'b1;
    tick();
    check("s_rst_h", s_h, 0);
    check("s_rst_v", s_v, 0);
    check("s_rst_de", s_de, 1);
    check("s_rst_hs", s_hs, 0);
    check("s_rst_vs", s_vs, 1);
    check("s_rst_ls", s_ls, 0);
    check("s_rst_fs", s_fs, 0);

    // Reset on the last pixel of a frame must suppress both pulses.
    rst_s = 1'b0;
    repeat (149) tick();
    check("s_end_h", s_h, 14);
    check("s_end_v", s_v, 9);
    rst_s = 1'b1;
    tick();
    check("s_wraprst_ls", s_ls, 0);
    check("s_wraprst_fs", s_fs, 0);
    check("s_wraprst_h", s_h, 0);
    check("s_wraprst_v", s_v, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator. It replaces the fixed 1056×628 counter pair with a generic horizontal/vertical timing engine that has configurable porches, sync widths, sync polarity and a pixel clock-enable. It produces registered hsync/vsync, a display-enable flag, pixel coordinates and line/frame pulses. It sits between the pixel clock domain and the tank/sprite renderers, which consume `count_h`/`count_v` and `de`.

## Interface
- `H_ACTIVE`, 800, visible pixels per line
- `H_FP`, 40, horizontal front porch (pixels)
- `H_SYNC`, 128, horizontal sync width (pixels)
- `H_BP`, 88, horizontal back porch (pixels)
- `V_ACTIVE`, 600, visible lines per frame
- `V_FP`, 1, vertical front porch (lines)
- `V_SYNC`, 4, vertical sync width (lines)
- `V_BP`, 23, vertical back porch (lines)
- `H_POL`, 1, hsync active level (1 = active-high)
- `V_POL`, 1, vsync active level
- `H_W`, 11, width of `count_h`; requires H_TOTAL ≤ 2^H_W
- `V_W`, 10, width of `count_v`; requires V_TOTAL ≤ 2^V_W
- `clk`  in  1  pixel clock
- `rst`  in  1  synchronous, active-high reset
- `ce`  in  1  pixel advance enable; counters and outputs hold while low
- `count_h`  out  H_W  horizontal position, 0..H_TOTAL-1
- `count_v`  out  V_W  vertical position, 0..V_TOTAL-1
- `hsync`  out  1  horizontal sync at level H_POL during sync interval
- `vsync`  out  1  vertical sync at level V_POL during sync interval
- `de`  out  1  display enable; high inside the active window
- `line_start`  out  1  one-cycle pulse when `count_h` becomes 0
- `frame_start`  out  1  one-cycle pulse when (`count_h`,`count_v`) becomes (0,0)

## Operation
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056) and V_TOTAL likewise (default 628).
- Horizontal order: active [0,H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch. Vertical order is the same, in lines.
- On `ce`, `count_h` increments. At H_TOTAL-1 it wraps to 0 and `count_v` increments in the same cycle. If `count_v` is at V_TOTAL-1 at that point, it wraps to 0. `count_v` changes only on an h-wrap, never mid-line.
- `de` = (`count_h` < H_ACTIVE) && (`count_v` < V_ACTIVE).
- `hsync`/`vsync` = active level inside their sync intervals, inverse level otherwise. vsync is decoded from `count_v` only, so it changes exactly at h-wrap.
- `line_start` is high for exactly one clk cycle after each h-wrap. `frame_start` is high for one cycle after a simultaneous h- and v-wrap. Both are 0 on any cycle where the preceding edge did not wrap, including when `ce` is low.
- Arithmetic is unsigned and uses fixed H_W/V_W widths. Compare against next-state values so no counter ever holds a value ≥ TOTAL.
- Synthesis-time check: H_TOTAL ≤ 2^H_W and V_TOTAL ≤ 2^V_W. Every interval parameter is ≥ 1.

## Timing
- All outputs are registered and update on the same `clk` edge as the counters, with zero skew between them. `hsync`/`vsync`/`de` are decoded from next-state counter values.
- Reset values: `count_h`=0, `count_v`=0, `de`=1, `hsync`=!H_POL, `vsync`=!V_POL, `line_start`=0, `frame_start`=0.
- Reset asserted mid-frame forces the reset values on the next edge, regardless of `ce`.
- `rst` and `ce` high together: reset wins.
- When `ce` is low, all outputs hold, except that the pulses drop to 0 after one cycle.
- Defaults give one line = 1056 `ce` cycles and one frame = 1056×628 = 663168 `ce` cycles.

## Structure
- Package `vga_timing_pkg` holds:
  - the default 800×600@60 constant set;
  - a 640×480@60 set (640/16/96/48, 480/10/2/33, polarity 0/0);
  - the H_TOTAL/V_TOTAL derivation functions.
- One sub-module, `vga_axis_counter`: a generic wrap counter with enable that also decodes active/sync. It is instantiated once for h and once for v; the v instance is enabled by `ce` && h-wrap.

## Test plan
- Reset, then hold `ce`=1 for 1056 cycles (defaults) → `count_h` runs 0..1055 and wraps to 0, `count_v`=1, `line_start` pulses once, `de` falls when `count_h` reaches 800.
- Run one full frame → `hsync` high for `count_h` 840..967 on every line; `vsync` high for lines 601..604; `frame_start` pulses exactly once after 663168 cycles; `count_v` never reaches 628.
- Toggle `ce` 1-0-1-0 pseudo-randomly → counters advance only on `ce`=1, the frame length counted in `ce` cycles is still 663168, and pulses stay one `clk` wide.
- Assert `rst` at (count_h=500, count_v=300) together with `ce`=1 → next edge gives 0/0, `de`=1, syncs inactive, and no pulse.
- Instantiate with the 640×480 set (H_POL=V_POL=0) → H_TOTAL 800, V_TOTAL 525, `hsync` low for `count_h` 656..751, `vsync` low for lines 490..491.
- Instantiate with the minimal config (all intervals 1, actives 2) → correct wrap at 5 for both axes and no out-of-range count.
